// File: rtl/instr_pkg.sv
// Shared field layout and enums for the 24-bit instruction word.
// This package is shared by the encoder and the decode stage.
package instr_pkg;

  localparam int unsigned OPC_HI = 23;
  localparam int unsigned OPC_LO = 20;
  localparam int unsigned RD_HI  = 19;
  localparam int unsigned RD_LO  = 16;
  localparam int unsigned RS1_HI = 15;
  localparam int unsigned RS1_LO = 12;
  localparam int unsigned RS2_HI = 11;
  localparam int unsigned RS2_LO = 8;
  localparam int unsigned IMM_HI = 15;
  localparam int unsigned IMM_LO = 0;

  typedef enum logic {FMT_R = 1'b0, FMT_I = 1'b1} fmt_e;

  typedef enum logic {LOAD = 1'b0, DONE = 1'b1} state_e;

endpackage

// File: rtl/instr_encoder_if.sv
// Loader-side bundle handshake plus the instruction memory write port.
interface instr_encoder_if #(
  parameter int unsigned WIDTH        = 24,
  parameter int unsigned ADDRESSWIDTH = 3,
  parameter int unsigned OPCODEWIDTH  = 4,
  parameter int unsigned MEMADDRWIDTH = 8
);
  logic                    clear;
  logic                    inValid;
  logic                    inReady;
  logic                    format;
  logic [OPCODEWIDTH-1:0]  opcode;
  logic [ADDRESSWIDTH-1:0] rd;
  logic [ADDRESSWIDTH-1:0] rs1;
  logic [ADDRESSWIDTH-1:0] rs2;
  logic [15:0]             imm;
  logic                    memWE;
  logic [MEMADDRWIDTH-1:0] memAddr;
  logic [WIDTH-1:0]        memData;
  logic [MEMADDRWIDTH:0]   count;
  logic                    done;

  modport master (
    output clear, inValid, format, opcode, rd, rs1, rs2, imm,
    input  inReady, memWE, memAddr, memData, count, done
  );

  modport slave (
    input  clear, inValid, format, opcode, rd, rs1, rs2, imm,
    output inReady, memWE, memAddr, memData, count, done
  );
endinterface

// File: rtl/instr_pack.sv
// Combinational packer from decoded fields to the instruction word.
// Register fields are zero-extended into their 4-bit slots.
module instr_pack
  import instr_pkg::*;
#(
  parameter int unsigned WIDTH        = 24,
  parameter int unsigned ADDRESSWIDTH = 3,
  parameter int unsigned OPCODEWIDTH  = 4
) (
  input  logic                    format,
  input  logic [OPCODEWIDTH-1:0]  opcode,
  input  logic [ADDRESSWIDTH-1:0] rd,
  input  logic [ADDRESSWIDTH-1:0] rs1,
  input  logic [ADDRESSWIDTH-1:0] rs2,
  input  logic [15:0]             imm,
  output logic [WIDTH-1:0]        word
);

  // Build the word field by field; unused bits stay zero.
  always_comb begin
    word = '0;
    word[OPC_LO +: OPCODEWIDTH] = opcode;
    word[RD_LO +: ADDRESSWIDTH] = rd;
    if (format == FMT_I) begin
      word[IMM_HI:IMM_LO] = imm;
    end else begin
      word[RS1_LO +: ADDRESSWIDTH] = rs1;
      word[RS2_LO +: ADDRESSWIDTH] = rs2;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Accepts field bundles, packs them and writes them to sequential
// instruction memory addresses until memory is full.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int unsigned WIDTH        = 24,
  parameter int unsigned ADDRESSWIDTH = 3,
  parameter int unsigned OPCODEWIDTH  = 4,
  parameter int unsigned MEMADDRWIDTH = 8
) (
  input logic           clock,
  input logic           reset,
  instr_encoder_if.slave bus
);

  localparam logic [MEMADDRWIDTH-1:0] LastAddr = '1;
  localparam logic [MEMADDRWIDTH-1:0] AddrOne  = MEMADDRWIDTH'(1);
  localparam logic [MEMADDRWIDTH:0]   CountOne = (MEMADDRWIDTH + 1)'(1);

  state_e                  state_q;
  logic [MEMADDRWIDTH-1:0] addr_q;
  logic [MEMADDRWIDTH:0]   count_q;
  logic                    we_q;
  logic [MEMADDRWIDTH-1:0] waddr_q;
  logic [WIDTH-1:0]        wdata_q;
  logic [WIDTH-1:0]        packed_word;
  logic                    transfer;

  instr_pack #(
    .WIDTH        (WIDTH),
    .ADDRESSWIDTH (ADDRESSWIDTH),
    .OPCODEWIDTH  (OPCODEWIDTH)
  ) u_pack (
    .format (bus.format),
    .opcode (bus.opcode),
    .rd     (bus.rd),
    .rs1    (bus.rs1),
    .rs2    (bus.rs2),
    .imm    (bus.imm),
    .word   (packed_word)
  );

  // clear blocks acceptance so a bundle is never lost into a restarting counter.
  assign bus.inReady = (state_q == LOAD) && !bus.clear;
  assign transfer    = bus.inValid && bus.inReady;

  assign bus.memWE   = we_q;
  assign bus.memAddr = waddr_q;
  assign bus.memData = wdata_q;
  assign bus.count   = count_q;
  assign bus.done    = (state_q == DONE);

  // FSM, address/count tracking and registered write port.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= LOAD;
      addr_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= transfer;
      if (bus.clear) begin
        // Memory contents and the last write-port values are left untouched.
        state_q <= LOAD;
        addr_q  <= '0;
        count_q <= '0;
      end else if (transfer) begin
        waddr_q <= addr_q;
        wdata_q <= packed_word;
        count_q <= count_q + CountOne;
        if (addr_q == LastAddr) begin
          // Address holds at the top; DONE blocks further writes.
          state_q <= DONE;
        end else begin
          addr_q <= addr_q + AddrOne;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed table, full-memory
// sequence, asynchronous reset and randomized traffic against a model.
module tb_instr_encoder;
  import instr_pkg::*;

  localparam int Depth = 256;

  logic clock;
  logic reset;

  instr_encoder_if #(
    .WIDTH        (24),
    .ADDRESSWIDTH (3),
    .OPCODEWIDTH  (4),
    .MEMADDRWIDTH (8)
  ) bus ();

  instr_encoder #(
    .WIDTH        (24),
    .ADDRESSWIDTH (3),
    .OPCODEWIDTH  (4),
    .MEMADDRWIDTH (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state: words written since reset/clear, last write port values.
  int          m_n    = 0;
  int          m_addr = 0;
  logic [23:0] m_data = '0;

  typedef struct {
    logic        v;
    logic        f;
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [15:0] imm;
    logic        clr;
    logic        exp_we;
    int          exp_addr;
    logic [23:0] exp_data;
    int          exp_count;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp_word(input logic f, input int op, input int rd,
                                           input int s1, input int s2, input int im);
    int w;
    w = op * (1 << 20) + rd * (1 << 16) + (f ? im : s1 * 4096 + s2 * 256);
    return w[23:0];
  endfunction

  // Present one cycle of inputs, predict the result and check it after the edge.
  task automatic step(input logic v, input logic f, input logic [3:0] op, input logic [2:0] d,
                      input logic [2:0] s1, input logic [2:0] s2, input logic [15:0] im,
                      input logic clr);
    logic ready;
    logic fire;
    bus.inValid = v;
    bus.format  = f;
    bus.opcode  = op;
    bus.rd      = d;
    bus.rs1     = s1;
    bus.rs2     = s2;
    bus.imm     = im;
    bus.clear   = clr;
    #1;
    ready = (m_n < Depth) && !clr;
    chk("inReady", 32'(bus.inReady), 32'(ready));
    fire = v && ready;
    if (fire) begin
      m_addr = m_n;
      m_data = exp_word(f, int'(op), int'(d), int'(s1), int'(s2), int'(im));
    end
    if (clr) m_n = 0;
    else if (fire) m_n = m_n + 1;
    @(posedge clock);
    #1;
    chk("memWE", 32'(bus.memWE), 32'(fire));
    chk("memAddr", 32'(bus.memAddr), 32'(m_addr));
    chk("memData", 32'(bus.memData), 32'(m_data));
    chk("count", 32'(bus.count), 32'(m_n));
    chk("done", 32'(bus.done), 32'(m_n == Depth));
  endtask

  task automatic rand_step(input logic v, input logic clr);
    step(v, 1'($urandom), 4'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
         16'($urandom), clr);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 4'h2, 3'd3, 3'd5, 3'd7, 16'h0000, 1'b0,
                1'b1, 0, 24'h235700, 1};
    vecs[1] = '{1'b1, 1'b1, 4'hA, 3'd1, 3'd6, 3'd2, 16'hBEEF, 1'b0,
                1'b1, 1, 24'hA1BEEF, 2};
    vecs[2] = '{1'b0, 1'b0, 4'hF, 3'd7, 3'd7, 3'd7, 16'hFFFF, 1'b0,
                1'b0, 1, 24'hA1BEEF, 2};
    vecs[3] = '{1'b1, 1'b0, 4'h3, 3'd2, 3'd2, 3'd2, 16'h1234, 1'b1,
                1'b0, 1, 24'hA1BEEF, 0};
    vecs[4] = '{1'b1, 1'b0, 4'h1, 3'd0, 3'd0, 3'd1, 16'h0000, 1'b0,
                1'b1, 0, 24'h100100, 1};

    reset       = 1'b1;
    bus.clear   = 1'b0;
    bus.inValid = 1'b0;
    bus.format  = 1'b0;
    bus.opcode  = '0;
    bus.rd      = '0;
    bus.rs1     = '0;
    bus.rs2     = '0;
    bus.imm     = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_inReady", 32'(bus.inReady), 32'd1);
    chk("rst_memWE", 32'(bus.memWE), 32'd0);
    chk("rst_memAddr", 32'(bus.memAddr), 32'd0);
    chk("rst_memData", 32'(bus.memData), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    @(posedge clock);
    #1;

    // Directed table, also cross-checked by the model inside step().
    for (int i = 0; i < 5; i++) begin
      step(vecs[i].v, vecs[i].f, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
           vecs[i].imm, vecs[i].clr);
      chk("tbl_memWE", 32'(bus.memWE), 32'(vecs[i].exp_we));
      chk("tbl_memAddr", 32'(bus.memAddr), 32'(vecs[i].exp_addr));
      chk("tbl_memData", 32'(bus.memData), 32'(vecs[i].exp_data));
      chk("tbl_count", 32'(bus.count), 32'(vecs[i].exp_count));
    end

    // Fill the whole memory back-to-back from address 0.
    rand_step(1'b1, 1'b1);
    for (int i = 0; i < Depth; i++) begin
      rand_step(1'b1, 1'b0);
      chk("fill_addr", 32'(bus.memAddr), 32'(i));
    end
    chk("full_done", 32'(bus.done), 32'd1);
    chk("full_inReady", 32'(bus.inReady), 32'd0);
    // 257th bundle must not be written.
    rand_step(1'b1, 1'b0);
    chk("extra_memWE", 32'(bus.memWE), 32'd0);

    // clear in DONE with a bundle present: nothing accepted that cycle.
    rand_step(1'b1, 1'b1);
    chk("clr_done_memWE", 32'(bus.memWE), 32'd0);
    chk("clr_done_count", 32'(bus.count), 32'd0);
    rand_step(1'b1, 1'b0);
    chk("after_clr_addr", 32'(bus.memAddr), 32'd0);
    chk("after_clr_we", 32'(bus.memWE), 32'd1);

    // Asynchronous reset between edges while memWE is high.
    rand_step(1'b1, 1'b0);
    bus.inValid = 1'b0;
    bus.clear   = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk("arst_memWE", 32'(bus.memWE), 32'd0);
    chk("arst_memAddr", 32'(bus.memAddr), 32'd0);
    chk("arst_memData", 32'(bus.memData), 32'd0);
    chk("arst_count", 32'(bus.count), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_inReady", 32'(bus.inReady), 32'd1);
    #1;
    reset  = 1'b0;
    m_n    = 0;
    m_addr = 0;
    m_data = '0;
    @(posedge clock);
    #1;

    // Random gaps, fields wandering while idle, occasional clear.
    for (int i = 0; i < 400; i++) begin
      rand_step(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 39) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
